// File: rtl/sd_lane_pkg.sv
// ---------------------------------------------------------------------------
// sd_lane_pkg
// Shared definitions for the SD block-lane arbiter: the lane FSM state type,
// the requester index constants, the default command timeout and a small
// helper for sizing requester index fields.
// ---------------------------------------------------------------------------
package sd_lane_pkg;

  // Lane FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } lane_state_t;

  // Requester slots on the lane.
  localparam int REQ_HDD = 0;
  localparam int REQ_FD1 = 1;
  localparam int REQ_FD2 = 2;

  // clk_sys cycles allowed between command issue and sd_ack rising.
  localparam logic [23:0] TIMEOUT_DEFAULT = 24'd8_000_000;

  // Width of an index into NREQ requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_lane_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority search. Starting one slot after the
// last served requester and wrapping at NREQ, the first requester with a
// pending bit set wins.
//
// Ports:
//   pending    in  NREQ  requesters with outstanding work
//   last       in  IW    index of the requester served most recently
//   winner     out NREQ  one-hot winner (all zero when nothing is pending)
//   winner_idx out IW    binary index of the winner
//   any        out 1     at least one requester is pending
// ---------------------------------------------------------------------------
module rr_pick
  import sd_lane_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   winner_idx,
  output logic            any
);

  int          cand_i;
  logic [IW-1:0] cand;

  // Walk the ring from last+1 for NREQ steps; the first hit is latched and
  // later hits are ignored, so the requester just served has lowest priority.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    cand_i     = 0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_i = int'(last) + k;
      if (cand_i >= NREQ) begin
        cand_i = cand_i - NREQ;
      end
      cand = cand_i[IW-1:0];
      if (!any && pending[cand]) begin
        any          = 1'b1;
        winner_idx   = cand;
        winner[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_lane_arbiter.sv
// ---------------------------------------------------------------------------
// sd_lane_arbiter
// Shares the single HPS SD block lane between NREQ block requesters (hard
// disk, floppy 1, floppy 2). Read/write pulses are latched as sticky pending
// bits, a round-robin search picks the next requester, and a four-state FSM
// issues the command, tracks the sd_ack handshake and reports completion or
// timeout back to the owning requester.
//
// Ports:
//   clk_sys      in  1        system clock
//   reset_n      in  1        asynchronous active-low reset
//   req_rd       in  NREQ     per-requester read-block pulse
//   req_wr       in  NREQ     per-requester write-block pulse
//   req_lba      in  NREQ*32  per-requester LBA, slot i at [32i+31:32i]
//   req_din      in  NREQ*8   per-requester write byte, slot i at [8i+7:8i]
//   pending      out NREQ     request latched and not yet served
//   grant        out NREQ     one-hot owner of the lane
//   done         out NREQ     one-cycle completion pulse
//   err          out NREQ     one-cycle timeout pulse
//   buff_wr      out NREQ     sd_buff_wr steered to the owner during XFER
//   sd_lba       out 32       LBA of the owner
//   sd_rd, sd_wr out 1        command strobes to the HPS lane
//   sd_ack       in  1        HPS acknowledge, high for the whole transfer
//   sd_buff_wr   in  1        HPS buffer write strobe
//   sd_buff_din  out 8        write byte of the owner, 8'h00 with no grant
//   cpu_wait     out 1        work outstanding or lane busy
// ---------------------------------------------------------------------------
module sd_lane_arbiter
  import sd_lane_pkg::*;
#(
  parameter int          NREQ    = 3,
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_rd,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*32-1:0] req_lba,
  input  logic [NREQ*8-1:0]  req_din,
  output logic [NREQ-1:0]    pending,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    err,
  output logic [NREQ-1:0]    buff_wr,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic               sd_buff_wr,
  output logic [7:0]         sd_buff_din,
  output logic               cpu_wait
);

  localparam int IW = idx_width(NREQ);

  lane_state_t     state;
  logic [NREQ-1:0] rd_p;
  logic [NREQ-1:0] wr_p;
  logic [IW-1:0]   last;
  logic [IW-1:0]   winner_idx;
  logic            serve_wr;
  logic [23:0]     counter;
  logic            ack_d;
  logic [7:0]      din_q;

  logic [31:0]     lba_arr [NREQ];
  logic [7:0]      din_arr [NREQ];

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            pick_wr;

  logic            ack_rise;
  logic            ack_fall;
  logic            timeout_hit;
  logic            issue_end;
  logic [NREQ-1:0] clr_rd;
  logic [NREQ-1:0] clr_wr;

  // Unpack the flat per-requester buses into indexable arrays.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign lba_arr[i] = req_lba[32*i +: 32];
    assign din_arr[i] = req_din[8*i +: 8];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .pending    (pending),
    .last       (last),
    .winner     (pick_oh),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  // Status outputs and handshake decode. The data byte is only presented
  // while someone owns the lane so idle cycles drive zero.
  assign pending     = rd_p | wr_p;
  assign cpu_wait    = (|pending) | (state != IDLE);
  assign buff_wr     = grant & {NREQ{sd_buff_wr & (state == XFER)}};
  assign sd_buff_din = (|grant) ? din_q : 8'h00;
  assign pick_wr     = |(wr_p & pick_oh);

  assign ack_rise    = sd_ack & ~ack_d;
  assign ack_fall    = ~sd_ack & ack_d;
  assign timeout_hit = (counter == (TIMEOUT - 24'd1));

  // The served pending bit clears when ISSUE ends, whether by acknowledge or
  // by timeout. grant is one-hot, so it selects the bit directly.
  assign issue_end = (state == ISSUE) & (ack_rise | timeout_hit);
  assign clr_wr    = (issue_end &  serve_wr) ? grant : '0;
  assign clr_rd    = (issue_end & ~serve_wr) ? grant : '0;

  // Lane FSM with registered strobes, grant and status pulses. Pending bits
  // are updated every cycle with the incoming pulse OR'ed in after the clear,
  // so a pulse landing on the clearing cycle keeps the bit set. Writes are
  // chosen ahead of reads for the same requester; the read stays pending.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rd_p       <= '0;
      wr_p       <= '0;
      grant      <= '0;
      done       <= '0;
      err        <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      sd_lba     <= '0;
      din_q      <= '0;
      counter    <= '0;
      last       <= IW'(NREQ - 1);
      winner_idx <= '0;
      serve_wr   <= 1'b0;
      ack_d      <= 1'b0;
    end else begin
      ack_d <= sd_ack;
      rd_p  <= (rd_p & ~clr_rd) | req_rd;
      wr_p  <= (wr_p & ~clr_wr) | req_wr;
      done  <= '0;
      err   <= '0;

      case (state)
        IDLE: begin
          if (pick_any) begin
            winner_idx <= pick_idx;
            grant      <= pick_oh;
            sd_lba     <= lba_arr[pick_idx];
            din_q      <= din_arr[pick_idx];
            serve_wr   <= pick_wr;
            sd_wr      <= pick_wr;
            sd_rd      <= ~pick_wr;
            counter    <= '0;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          if (ack_rise) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= XFER;
          end else if (timeout_hit) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            err   <= grant;
            last  <= winner_idx;
            grant <= '0;
            state <= IDLE;
          end else begin
            counter <= counter + 24'd1;
          end
        end

        XFER: begin
          if (ack_fall) begin
            done  <= grant;
            state <= DONE;
          end
        end

        DONE: begin
          last  <= winner_idx;
          grant <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_lane_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_lane_arbiter
// Self-checking bench for sd_lane_arbiter. Directed scenarios cover reset,
// single read latency, round-robin order, write-before-read, buffer strobe
// steering, timeout and reset mid-transfer; a randomized scenario compares
// every issued command against a queue-free round-robin reference model.
// ---------------------------------------------------------------------------
module tb_sd_lane_arbiter;

  localparam int N = 3;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_rd;
  logic [N-1:0]  req_wr;
  logic [N*32-1:0] req_lba;
  logic [N*8-1:0]  req_din;
  logic [N-1:0]  pending;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic [N-1:0]  err;
  logic [N-1:0]  buff_wr;
  logic [31:0]   sd_lba;
  logic          sd_rd;
  logic          sd_wr;
  logic          sd_ack;
  logic          sd_buff_wr;
  logic [7:0]    sd_buff_din;
  logic          cpu_wait;

  logic [31:0]   lba_m [N];
  logic [7:0]    din_m [N];

  // Reference model: sticky request flags and the last served slot.
  logic [N-1:0]  mrd;
  logic [N-1:0]  mwr;
  int            mlast;

  int checks = 0;
  int errors = 0;

  assign req_lba = {lba_m[2], lba_m[1], lba_m[0]};
  assign req_din = {din_m[2], din_m[1], din_m[0]};

  always #5 clk_sys = ~clk_sys;

  sd_lane_arbiter #(
    .NREQ    (N),
    .TIMEOUT (24'd16)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_lba     (req_lba),
    .req_din     (req_din),
    .pending     (pending),
    .grant       (grant),
    .done        (done),
    .err         (err),
    .buff_wr     (buff_wr),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din),
    .cpu_wait    (cpu_wait)
  );

  task automatic tick();
    @(negedge clk_sys);
  endtask

  // Round-robin rule: first pending slot after the last served one.
  function automatic int predict_winner();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (mlast + k) % N;
      if (mrd[j] || mwr[j]) return j;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset_n    = 1'b0;
    req_rd     = '0;
    req_wr     = '0;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    mrd        = '0;
    mwr        = '0;
    mlast      = N - 1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // One-cycle request pulse, mirrored into the model.
  task automatic pulse(input logic [N-1:0] rd, input logic [N-1:0] wr);
    req_rd = rd;
    req_wr = wr;
    mrd    = mrd | rd;
    mwr    = mwr | wr;
    tick();
    req_rd = '0;
    req_wr = '0;
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sd_rd || sd_wr) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Plays the HPS side of one transfer and reports what it observed.
  task automatic serve(input int dly, input int len, input bit rnd,
                       output logic [N-1:0] g, output logic sw, output logic sr,
                       output logic [31:0] lba, output logic [7:0] din,
                       output logic [N-1:0] dn, output logic [N-1:0] er,
                       output bit ok);
    wait_strobe(40, ok);
    g   = grant;
    sw  = sd_wr;
    sr  = sd_rd;
    lba = sd_lba;
    din = sd_buff_din;
    dn  = '0;
    er  = '0;
    if (!ok) return;
    repeat (dly) tick();
    sd_ack = 1'b1;
    tick();
    for (int i = 1; i < len; i++) begin
      if (rnd && ($urandom_range(0, 2) == 0)) begin
        logic [N-1:0] r;
        logic [N-1:0] w;
        r = N'($urandom_range(0, 7));
        w = N'($urandom_range(0, 7)) & N'($urandom_range(0, 7));
        for (int k = 0; k < N; k++) begin
          if (r[k] || w[k]) begin
            lba_m[k] = $urandom();
            din_m[k] = 8'($urandom());
          end
        end
        pulse(r, w);
      end else begin
        tick();
      end
    end
    sd_ack = 1'b0;
    tick();
    dn = done;
    er = err;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    if (pending !== 3'b000) begin errors++; $display("[TB] FAIL reset_pending: got %0h expected 0", pending); end
    checks++;
    if (grant !== 3'b000) begin errors++; $display("[TB] FAIL reset_grant: got %0h expected 0", grant); end
    checks++;
    if ({done, err} !== 6'b0) begin errors++; $display("[TB] FAIL reset_done_err: got %0h expected 0", {done, err}); end
    checks++;
    if ({sd_rd, sd_wr} !== 2'b00) begin errors++; $display("[TB] FAIL reset_strobes: got %0h expected 0", {sd_rd, sd_wr}); end
    checks++;
    if (sd_lba !== 32'h0) begin errors++; $display("[TB] FAIL reset_lba: got %0h expected 0", sd_lba); end
    checks++;
    if ({cpu_wait, sd_buff_din, buff_wr} !== 12'h0) begin errors++; $display("[TB] FAIL reset_misc: got %0h expected 0", {cpu_wait, sd_buff_din, buff_wr}); end
    checks++;
  endtask

  task automatic test_single_read();
    apply_reset();
    lba_m[0] = 32'h10;
    pulse(3'b001, 3'b000);
    if (sd_rd !== 1'b0) begin errors++; $display("[TB] FAIL early_strobe: got %0b expected 0", sd_rd); end
    checks++;
    if ({pending, cpu_wait} !== 4'b0011) begin errors++; $display("[TB] FAIL latched_pending: got %0h expected 3", {pending, cpu_wait}); end
    checks++;
    tick();
    if ({sd_rd, sd_wr, grant} !== 5'b10001) begin errors++; $display("[TB] FAIL read_issue: got %0h expected 11", {sd_rd, sd_wr, grant}); end
    checks++;
    if (sd_lba !== 32'h10) begin errors++; $display("[TB] FAIL read_lba: got %0h expected 10", sd_lba); end
    checks++;
    sd_ack = 1'b1;
    tick();
    if ({sd_rd, pending} !== 4'b0000) begin errors++; $display("[TB] FAIL ack_drop: got %0h expected 0", {sd_rd, pending}); end
    checks++;
    repeat (3) tick();
    sd_ack = 1'b0;
    tick();
    if ({done, err} !== 6'b001000) begin errors++; $display("[TB] FAIL read_done: got %0h expected 8", {done, err}); end
    checks++;
    tick();
    if ({done, grant, cpu_wait} !== 7'b0) begin errors++; $display("[TB] FAIL read_idle: got %0h expected 0", {done, grant, cpu_wait}); end
    checks++;
  endtask

  task automatic test_round_robin();
    int exp_order [3] = '{0, 1, 2};
    logic [N-1:0] g, dn, er;
    logic sw, sr;
    logic [31:0] lba;
    logic [7:0] din;
    bit ok;
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      pulse(3'b111, 3'b000);
      for (int t = 0; t < 3; t++) begin
        serve(1, 2, 1'b0, g, sw, sr, lba, din, dn, er, ok);
        if (!ok || g !== N'(1 << exp_order[t])) begin errors++; $display("[TB] FAIL rr_order: got %0h expected %0h", g, 1 << exp_order[t]); end
        checks++;
        if (dn !== N'(1 << exp_order[t])) begin errors++; $display("[TB] FAIL rr_done: got %0h expected %0h", dn, 1 << exp_order[t]); end
        checks++;
      end
    end
    if (cpu_wait !== 1'b0) begin errors++; $display("[TB] FAIL rr_cpu_wait: got %0b expected 0", cpu_wait); end
    checks++;
  endtask

  task automatic test_write_first();
    logic [N-1:0] g, dn, er;
    logic sw, sr;
    logic [31:0] lba;
    logic [7:0] din;
    bit ok;
    apply_reset();
    pulse(3'b010, 3'b010);
    serve(0, 1, 1'b0, g, sw, sr, lba, din, dn, er, ok);
    if (!ok || {g, sw, sr, dn} !== {3'b010, 2'b10, 3'b010}) begin errors++; $display("[TB] FAIL write_first: got %0h expected %0h", {g, sw, sr, dn}, {3'b010, 2'b10, 3'b010}); end
    checks++;
    serve(2, 3, 1'b0, g, sw, sr, lba, din, dn, er, ok);
    if (!ok || {g, sw, sr, dn} !== {3'b010, 2'b01, 3'b010}) begin errors++; $display("[TB] FAIL read_second: got %0h expected %0h", {g, sw, sr, dn}, {3'b010, 2'b01, 3'b010}); end
    checks++;
  endtask

  task automatic test_buff_steer();
    logic [7:0] b2;
    bit ok;
    apply_reset();
    b2 = 8'($urandom());
    din_m[2] = b2;
    din_m[1] = b2 ^ 8'h5a;
    din_m[0] = ~b2;
    pulse(3'b100, 3'b000);
    wait_strobe(10, ok);
    if (!ok || grant !== 3'b100 || sd_buff_din !== b2) begin errors++; $display("[TB] FAIL steer_issue: got %0h expected %0h", {grant, sd_buff_din}, {3'b100, b2}); end
    checks++;
    sd_buff_wr = 1'b1;
    tick();
    if (buff_wr !== 3'b000) begin errors++; $display("[TB] FAIL buff_wr_in_issue: got %0h expected 0", buff_wr); end
    checks++;
    sd_ack = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      sd_buff_wr = i[0];
      #1;
      if (buff_wr !== {sd_buff_wr, 2'b00} || sd_buff_din !== b2) begin errors++; $display("[TB] FAIL buff_wr_steer: got %0h expected %0h", {buff_wr, sd_buff_din}, {sd_buff_wr, 2'b00, b2}); end
      checks++;
      tick();
    end
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    repeat (2) tick();
    sd_buff_wr = 1'b1;
    #1;
    if ({buff_wr, sd_buff_din} !== 11'h0) begin errors++; $display("[TB] FAIL no_grant_buff: got %0h expected 0", {buff_wr, sd_buff_din}); end
    checks++;
    sd_buff_wr = 1'b0;
  endtask

  task automatic test_timeout();
    logic [N-1:0] g, dn, er;
    logic sw, sr;
    logic [31:0] lba;
    logic [7:0] din;
    bit ok;
    int cnt;
    apply_reset();
    pulse(3'b011, 3'b000);
    wait_strobe(10, ok);
    cnt = 0;
    while (sd_rd && cnt < 100) begin
      cnt++;
      tick();
    end
    if (!ok || cnt != 16) begin errors++; $display("[TB] FAIL timeout_len: got %0d expected 16", cnt); end
    checks++;
    if ({err, done, pending, grant} !== {3'b001, 3'b000, 3'b010, 3'b000}) begin errors++; $display("[TB] FAIL timeout_err: got %0h expected %0h", {err, done, pending, grant}, {3'b001, 3'b000, 3'b010, 3'b000}); end
    checks++;
    tick();
    if ({err, grant, sd_rd} !== {3'b000, 3'b010, 1'b1}) begin errors++; $display("[TB] FAIL timeout_next: got %0h expected %0h", {err, grant, sd_rd}, {3'b000, 3'b010, 1'b1}); end
    checks++;
    serve(0, 2, 1'b0, g, sw, sr, lba, din, dn, er, ok);
    if (!ok || {dn, er} !== {3'b010, 3'b000}) begin errors++; $display("[TB] FAIL after_timeout_done: got %0h expected %0h", {dn, er}, {3'b010, 3'b000}); end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] g, dn, er;
    logic sw, sr;
    logic [31:0] lba;
    logic [7:0] din;
    bit ok;
    apply_reset();
    lba_m[0] = 32'h10;
    pulse(3'b001, 3'b000);
    tick();
    sd_ack = 1'b1;
    req_rd = 3'b001;
    tick();
    req_rd = 3'b000;
    if ({pending, sd_rd, grant} !== {3'b001, 1'b0, 3'b001}) begin errors++; $display("[TB] FAIL pulse_on_clear: got %0h expected %0h", {pending, sd_rd, grant}, {3'b001, 1'b0, 3'b001}); end
    checks++;
    lba_m[0] = 32'hBEEF;
    pulse(3'b000, 3'b001);
    if (sd_lba !== 32'h10 || sd_wr !== 1'b0) begin errors++; $display("[TB] FAIL inflight_stable: got %0h expected 10", {sd_wr, sd_lba}); end
    checks++;
    sd_ack = 1'b0;
    tick();
    if (done !== 3'b001) begin errors++; $display("[TB] FAIL inflight_done: got %0h expected 1", done); end
    checks++;
    tick();
    serve(1, 1, 1'b0, g, sw, sr, lba, din, dn, er, ok);
    if (!ok || {g, sw, lba, dn} !== {3'b001, 1'b1, 32'hBEEF, 3'b001}) begin errors++; $display("[TB] FAIL relatched_write: got %0h expected %0h", {g, sw, lba, dn}, {3'b001, 1'b1, 32'hBEEF, 3'b001}); end
    checks++;
    serve(0, 2, 1'b0, g, sw, sr, lba, din, dn, er, ok);
    if (!ok || {g, sr, dn} !== {3'b001, 1'b1, 3'b001}) begin errors++; $display("[TB] FAIL relatched_read: got %0h expected %0h", {g, sr, dn}, {3'b001, 1'b1, 3'b001}); end
    checks++;
  endtask

  task automatic test_reset_mid_xfer();
    logic [N-1:0] g, dn, er;
    logic sw, sr;
    logic [31:0] lba;
    logic [7:0] din;
    bit ok;
    bit stray;
    apply_reset();
    lba_m[0] = 32'h1234;
    pulse(3'b001, 3'b000);
    tick();
    sd_ack = 1'b1;
    repeat (2) tick();
    pulse(3'b010, 3'b000);
    sd_buff_wr = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    if ({grant, pending, done, err, buff_wr} !== 15'h0) begin errors++; $display("[TB] FAIL async_reset_vec: got %0h expected 0", {grant, pending, done, err, buff_wr}); end
    checks++;
    if ({sd_rd, sd_wr, sd_lba, sd_buff_din, cpu_wait} !== 43'h0) begin errors++; $display("[TB] FAIL async_reset_lane: got %0h expected 0", {sd_rd, sd_wr, sd_lba, sd_buff_din, cpu_wait}); end
    checks++;
    tick();
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick();
    reset_n = 1'b1;
    mrd = '0;
    mwr = '0;
    mlast = N - 1;
    stray = 1'b0;
    repeat (3) begin
      tick();
      if (done !== 3'b000 || err !== 3'b000) stray = 1'b1;
    end
    if (stray !== 1'b0) begin errors++; $display("[TB] FAIL abandoned_pulse: got %0b expected 0", stray); end
    checks++;
    pulse(3'b000, 3'b100);
    tick();
    if ({sd_wr, sd_rd, grant} !== {2'b10, 3'b100}) begin errors++; $display("[TB] FAIL post_reset_issue: got %0h expected %0h", {sd_wr, sd_rd, grant}, {2'b10, 3'b100}); end
    checks++;
    serve(0, 2, 1'b0, g, sw, sr, lba, din, dn, er, ok);
    if (!ok || {dn, er} !== {3'b100, 3'b000}) begin errors++; $display("[TB] FAIL post_reset_done: got %0h expected %0h", {dn, er}, {3'b100, 3'b000}); end
    checks++;
  endtask

  task automatic test_random();
    logic [N-1:0] g, dn, er;
    logic sw, sr;
    logic [31:0] lba, exp_lba;
    logic [7:0] din, exp_din;
    logic [N-1:0] r, w;
    logic op;
    int wi;
    int guard;
    bit ok;
    bit broken;
    apply_reset();
    broken = 1'b0;
    for (int round = 0; round < 30 && !broken; round++) begin
      r = N'($urandom_range(0, 7));
      w = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 7)) : '0;
      if ((r | w) == '0) r = N'(1 << $urandom_range(0, N - 1));
      for (int k = 0; k < N; k++) begin
        lba_m[k] = $urandom();
        din_m[k] = 8'($urandom());
      end
      pulse(r, w);
      guard = 0;
      while ((mrd | mwr) != '0 && guard < 60 && !broken) begin
        guard++;
        wi = predict_winner();
        op = mwr[wi];
        if (op) mwr[wi] = 1'b0;
        else    mrd[wi] = 1'b0;
        exp_lba = lba_m[wi];
        exp_din = din_m[wi];
        serve($urandom_range(0, 3), $urandom_range(1, 4), 1'b1, g, sw, sr, lba, din, dn, er, ok);
        if (!ok) begin
          errors++;
          $display("[TB] FAIL rand_no_strobe: got none expected slot %0d", wi);
          broken = 1'b1;
        end else begin
          if ({g, sw, sr} !== {N'(1 << wi), op, ~op}) begin errors++; $display("[TB] FAIL rand_cmd: got %0h expected %0h", {g, sw, sr}, {N'(1 << wi), op, ~op}); end
          if ({lba, din} !== {exp_lba, exp_din}) begin errors++; $display("[TB] FAIL rand_data: got %0h expected %0h", {lba, din}, {exp_lba, exp_din}); end
          checks++;
          if ({dn, er} !== {N'(1 << wi), 3'b000}) begin errors++; $display("[TB] FAIL rand_done: got %0h expected %0h", {dn, er}, {N'(1 << wi), 3'b000}); end
          mlast = wi;
        end
        checks++;
      end
    end
    tick();
    if ({pending, cpu_wait} !== {(mrd | mwr), 1'b0}) begin errors++; $display("[TB] FAIL rand_drained: got %0h expected %0h", {pending, cpu_wait}, {(mrd | mwr), 1'b0}); end
    checks++;
  endtask

  initial begin
    reset_n    = 1'b0;
    req_rd     = '0;
    req_wr     = '0;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    for (int k = 0; k < N; k++) begin
      lba_m[k] = '0;
      din_m[k] = '0;
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_first();
    test_buff_steer();
    test_timeout();
    test_back_to_back();
    test_reset_mid_xfer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
